// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: target/next-PC selection plus a circular return-address stack.
// Latency one cycle, registered outputs only; no backpressure, one operation accepted per cycle.
module branch_resolve_unit #(
    parameter int WordSize = 32,
    parameter int RasDepth = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [1:0]                    addr_mode,
    input  logic                          branch_taken,
    input  logic                          is_call,
    input  logic [WordSize-1:0]           imm,
    input  logic [WordSize-1:0]           rs1d,
    input  logic [WordSize-1:0]           pc_in,
    output logic                          out_valid,
    output logic                          redirect_valid,
    output logic [WordSize-1:0]           branch_addr,
    output logic [WordSize-1:0]           npc,
    output logic                          misalign,
    output logic [$clog2(RasDepth+1)-1:0] ras_count
);

    localparam int PtrW = $clog2(RasDepth);
    localparam int CntW = $clog2(RasDepth + 1);

    logic [WordSize-1:0] ras_mem [RasDepth];
    logic [PtrW-1:0]     ras_ptr;
    logic [CntW-1:0]     ras_cnt;

    logic                acc;
    logic                ras_empty;
    logic [WordSize-1:0] reg_sum;
    logic [WordSize-1:0] reg_tgt;
    logic [WordSize-1:0] tgt;
    logic                mis;
    logic                ras_upd;
    logic                do_push;
    logic                do_pop;
    logic [WordSize-1:0] link;
    logic [PtrW-1:0]     wr_idx;

    always_comb begin
        acc       = in_valid & ~flush;
        ras_empty = (ras_cnt == '0);
        reg_sum   = imm + rs1d;
        reg_tgt   = {reg_sum[WordSize-1:1], 1'b0};
        tgt       = pc_in + imm;
        case (addr_mode)
            2'b01:   tgt = reg_tgt;
            // A return with nothing stacked falls back to the register-relative target.
            2'b10:   tgt = ras_empty ? reg_tgt : ras_mem[ras_ptr];
            default: tgt = pc_in + imm;
        endcase
        mis     = branch_taken & (tgt[1:0] != 2'b00);
        ras_upd = acc & branch_taken & ~mis;
        do_push = ras_upd & is_call;
        do_pop  = ras_upd & (addr_mode == 2'b10) & ~ras_empty;
        link    = pc_in + WordSize'(4);
        // Return-call replaces the top in place; a plain push goes one slot above it.
        wr_idx  = do_pop ? ras_ptr : ras_ptr + PtrW'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[wr_idx] <= link;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (do_push && !do_pop) begin
            ras_ptr <= ras_ptr + PtrW'(1);
            if (ras_cnt != CntW'(RasDepth)) begin
                ras_cnt <= ras_cnt + CntW'(1);
            end
        end else if (do_pop && !do_push) begin
            ras_ptr <= ras_ptr - PtrW'(1);
            ras_cnt <= ras_cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
            misalign       <= 1'b0;
            branch_addr    <= '0;
            npc            <= '0;
        end else begin
            out_valid      <= acc;
            redirect_valid <= acc & branch_taken & ~mis;
            misalign       <= acc & mis;
            if (acc) begin
                branch_addr <= tgt;
                npc         <= branch_taken ? tgt : pc_in;
            end
        end
    end

    assign ras_count = ras_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-derived expectations queued at drive time, checked one cycle later.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [1:0]  addr_mode;
    logic        branch_taken;
    logic        is_call;
    logic [31:0] imm;
    logic [31:0] rs1d;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        redirect_valid;
    logic [31:0] branch_addr;
    logic [31:0] npc;
    logic        misalign;
    logic [2:0]  ras_count;

    typedef struct {
        string       tag;
        logic        ov;
        logic        rv;
        logic [31:0] ba;
        logic [31:0] npc;
        logic        mis;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    branch_resolve_unit #(.WordSize(32), .RasDepth(4)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
        .addr_mode(addr_mode), .branch_taken(branch_taken), .is_call(is_call),
        .imm(imm), .rs1d(rs1d), .pc_in(pc_in),
        .out_valid(out_valid), .redirect_valid(redirect_valid),
        .branch_addr(branch_addr), .npc(npc), .misalign(misalign),
        .ras_count(ras_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk({e.tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
        chk({e.tag, ".redirect"}, 32'(redirect_valid), 32'(e.rv));
        chk({e.tag, ".branch_addr"}, branch_addr, e.ba);
        chk({e.tag, ".npc"}, npc, e.npc);
        chk({e.tag, ".misalign"}, 32'(misalign), 32'(e.mis));
        chk({e.tag, ".ras_count"}, 32'(ras_count), 32'(e.cnt));
    endtask

    // Drive one operation, queue its expected outcome, and score it after the next rising edge.
    task automatic step(input string tag, input logic v, input logic fl, input logic [1:0] md,
                        input logic tk, input logic cl, input logic [31:0] im,
                        input logic [31:0] r1, input logic [31:0] pc,
                        input logic e_ov, input logic e_rv, input logic [31:0] e_ba,
                        input logic [31:0] e_npc, input logic e_mis, input logic [2:0] e_cnt);
        exp_t e;
        in_valid = v; flush = fl; addr_mode = md; branch_taken = tk; is_call = cl;
        imm = im; rs1d = r1; pc_in = pc;
        e.tag = tag; e.ov = e_ov; e.rv = e_rv; e.ba = e_ba; e.npc = e_npc; e.mis = e_mis; e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s.scoreboard: observed empty queue expected an entry", tag);
        end
        if (sb.size() > 0) check_all(sb.pop_front());
    endtask

    initial begin
        exp_t z;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; addr_mode = 2'b00;
        branch_taken = 1'b0; is_call = 1'b0; imm = '0; rs1d = '0; pc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        z.tag = "reset"; z.ov = 0; z.rv = 0; z.ba = 0; z.npc = 0; z.mis = 0; z.cnt = 0;
        check_all(z);
        rstn = 1'b1;

        //    tag          v  fl md     tk cl imm           rs1           pc            ov rv ba            npc           mis cnt
        step("pcrel_tk",   1, 0, 2'b00, 1, 0, 32'h40,       32'h0,        32'h100,      1, 1, 32'h140,      32'h140,      0, 0);
        step("idle_hold",  0, 0, 2'b00, 1, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'h140,      32'h140,      0, 0);
        step("pcrel_nt",   1, 0, 2'b00, 0, 0, 32'h40,       32'h0,        32'h100,      1, 0, 32'h140,      32'h100,      0, 0);
        step("mode11",     1, 0, 2'b11, 1, 0, 32'h40,       32'h0,        32'h100,      1, 1, 32'h140,      32'h140,      0, 0);
        step("regrel",     1, 0, 2'b01, 1, 0, 32'h4,        32'h201,      32'h300,      1, 1, 32'h204,      32'h204,      0, 0);
        step("misalign",   1, 0, 2'b01, 1, 1, 32'h0,        32'h202,      32'h300,      1, 0, 32'h202,      32'h202,      1, 0);
        step("carry_wrap", 1, 0, 2'b00, 1, 0, 32'h20,       32'h0,        32'hFFFF_FFF0,1, 1, 32'h10,       32'h10,       0, 0);
        step("call_1000",  1, 0, 2'b00, 1, 1, 32'h20,       32'h0,        32'h1000,     1, 1, 32'h1020,     32'h1020,     0, 1);
        step("ret_1004",   1, 0, 2'b10, 1, 0, 32'h0,        32'hDEAD0,    32'h1020,     1, 1, 32'h1004,     32'h1004,     0, 0);
        step("ret_empty",  1, 0, 2'b10, 1, 0, 32'h0,        32'hDEAD0,    32'h1004,     1, 1, 32'hDEAD0,    32'hDEAD0,    0, 0);

        for (int i = 0; i < 5; i++) begin
            logic [31:0] p;
            logic [2:0]  c;
            p = 32'(i * 16);
            c = (i < 4) ? 3'(i + 1) : 3'd4;
            step($sformatf("ovf_call%0d", i), 1, 0, 2'b00, 1, 1, 32'h8, 32'h0, p,
                 1, 1, p + 32'h8, p + 32'h8, 0, c);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = 32'h44 - 32'(i * 16);
            step($sformatf("ovf_ret%0d", i), 1, 0, 2'b10, 1, 0, 32'h0, 32'hDEAD0, 32'h900,
                 1, 1, t, t, 0, 3'(3 - i));
        end

        step("call_100",   1, 0, 2'b00, 1, 1, 32'h10,       32'h0,        32'h100,      1, 1, 32'h110,      32'h110,      0, 1);
        step("flush_call", 1, 1, 2'b00, 1, 1, 32'h10,       32'h0,        32'h200,      0, 0, 32'h110,      32'h110,      0, 1);
        step("ret_call",   1, 0, 2'b10, 1, 1, 32'h0,        32'hDEAD0,    32'h500,      1, 1, 32'h104,      32'h104,      0, 1);
        step("ret_504",    1, 0, 2'b10, 1, 0, 32'h0,        32'hDEAD0,    32'h600,      1, 1, 32'h504,      32'h504,      0, 0);
        step("nt_call",    1, 0, 2'b00, 0, 1, 32'h10,       32'h0,        32'h700,      1, 0, 32'h710,      32'h700,      0, 0);
        step("retcall_mt", 1, 0, 2'b10, 1, 1, 32'h0,        32'hDEAD0,    32'h800,      1, 1, 32'hDEAD0,    32'hDEAD0,    0, 1);
        step("call_900",   1, 0, 2'b00, 1, 1, 32'h4,        32'h0,        32'h900,      1, 1, 32'h904,      32'h904,      0, 2);

        // Reset lands between edges while another call is being presented.
        in_valid = 1'b1; flush = 1'b0; addr_mode = 2'b00; branch_taken = 1'b1; is_call = 1'b1;
        imm = 32'h4; rs1d = 32'h0; pc_in = 32'hA00;
        #3;
        rstn = 1'b0;
        #1;
        z.tag = "async_rst";
        check_all(z);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        step("post_rst",   1, 0, 2'b10, 1, 0, 32'h0,        32'hABC0,     32'h40,       1, 1, 32'hABC0,     32'hABC0,     0, 0);
        step("final_idle", 0, 0, 2'b00, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 32'hABC0,     32'hABC0,     0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
